// File: rtl/game_turn_controller.sv
// Bulls-and-cows turn controller: secrets, guesses, scoring, win/draw.
// Optional TURN_LIMIT_EN enables a draw after MAX_TURNS rounds.
module game_turn_controller #(
    parameter int MAX_TURNS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        confirma,
    input  logic [15:0] SW,
    input  logic [2:0]  bulls_i,
    input  logic [2:0]  cows_i,
    output logic [15:0] score_guess_o,
    output logic [15:0] score_secret_o,
    output logic [2:0]  state_o,
    output logic        player_o,
    output logic [5:0]  result_o,
    output logic        entry_err_o,
    output logic [1:0]  winner_o,
    output logic [3:0]  turn_o
);

    typedef enum logic [2:0] {
        SECRET1 = 3'd0,
        SECRET2 = 3'd1,
        GUESS   = 3'd2,
        SCORE   = 3'd3,
        SHOW    = 3'd4,
        WIN     = 3'd5,
        DRAW    = 3'd6
    } state_t;

`ifdef TURN_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif
    localparam logic [3:0] LIMIT = 4'(MAX_TURNS);

    state_t      state;
    logic [15:0] secret1;
    logic [15:0] secret2;
    logic        sync1;
    logic        sync2;
    logic        sync2_d;
    logic        conf_p;
    logic        sw_ok;
    logic [3:0]  turn_next;
    logic        draw_hit;

    function automatic logic entry_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < 4; j++)
                if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
        end
        return ok;
    endfunction

    assign conf_p         = sync2 & ~sync2_d;
    assign sw_ok          = entry_ok(SW);
    assign turn_next      = turn_o + 4'd1;
    assign draw_hit       = LIMIT_ON && (turn_next == LIMIT);
    assign state_o        = state;
    assign score_secret_o = player_o ? secret1 : secret2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= confirma;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= SECRET1;
            player_o      <= 1'b0;
            secret1       <= '0;
            secret2       <= '0;
            score_guess_o <= '0;
            result_o      <= '0;
            entry_err_o   <= 1'b0;
            winner_o      <= 2'b00;
            turn_o        <= '0;
        end else begin
            unique case (state)
                SECRET1: if (conf_p) begin
                    if (sw_ok) begin
                        secret1     <= SW;
                        entry_err_o <= 1'b0;
                        state       <= SECRET2;
                    end else begin
                        entry_err_o <= 1'b1;
                    end
                end
                SECRET2: if (conf_p) begin
                    if (sw_ok) begin
                        secret2     <= SW;
                        entry_err_o <= 1'b0;
                        player_o    <= 1'b0;
                        state       <= GUESS;
                    end else begin
                        entry_err_o <= 1'b1;
                    end
                end
                GUESS: if (conf_p) begin
                    if (sw_ok) begin
                        score_guess_o <= SW;
                        entry_err_o   <= 1'b0;
                        state         <= SCORE;
                    end else begin
                        entry_err_o <= 1'b1;
                    end
                end
                SCORE: begin
                    result_o <= {bulls_i, cows_i};
                    state    <= SHOW;
                end
                SHOW: if (conf_p) begin
                    if (result_o[5:3] == 3'd4) begin
                        winner_o <= player_o ? 2'b10 : 2'b01;
                        state    <= WIN;
                    end else if (player_o && draw_hit) begin
                        winner_o <= 2'b11;
                        turn_o   <= turn_next;
                        state    <= DRAW;
                    end else begin
                        if (player_o) turn_o <= turn_next;
                        player_o <= ~player_o;
                        state    <= GUESS;
                    end
                end
                WIN, DRAW: ;
                default: state <= SECRET1;
            endcase
        end
    end

endmodule
